// File: rtl/ps2_keyb_rx.sv
// PS/2 keyboard receiver: frame deserialiser, scan-code FIFO, data/status read port
// and a toggle interrupt that flips once per byte handed to software.
//
// state  | meaning
// -------+----------------------------------------------------------
// IDLE   | waiting for a falling edge with data low (start bit)
// DATA   | shifting in D0..D7, LSB first, one bit per falling edge
// PARITY | next falling edge captures the parity bit
// STOP   | next falling edge checks stop=1 and odd parity, push or flag
module ps2_keyb_rx #(
    parameter int DEPTH_LOG2 = 3,
    parameter int TIMEOUT    = 12500
) (
    input  logic       CLOCK,
    input  logic       RESET_N,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic       I_ADDR,
    input  logic       I_RD,
    output logic [7:0] O_DATA,
    output logic       IRQ_KEYB
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW    = DEPTH_LOG2 + 1;
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_nxt;

    logic                  clk_s1, clk_s2, clk_s3, dat_s1, dat_s2;
    logic                  fall, tmo;
    logic [7:0]            shift_q;
    logic [2:0]            bitcnt;
    logic                  par_q;
    logic [TW-1:0]         tmr;
    logic                  frame_ok, frame_err;

    logic [7:0]            mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0]         count, count_nxt;
    logic                  ferr, ovf;
    logic                  empty, full, data_rd, stat_rd, pop, push, drop, irq_tgl;
    logic [7:0]            stat_byte;

    // clk_s3 is the previous synchronised clock level, used only for edge detect
    assign fall = clk_s3 & ~clk_s2;
    assign tmo  = (state != IDLE) && !fall && (tmr == TW'(TIMEOUT));

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        frame_ok  = 1'b0;
        frame_err = 1'b0;
        if (tmo) begin
            state_nxt = IDLE;
            frame_err = 1'b1;
        end else if (fall) begin
            case (state)
                IDLE:    if (!dat_s2) state_nxt = DATA;
                DATA:    if (bitcnt == 3'd7) state_nxt = PARITY;
                PARITY:  state_nxt = STOP;
                STOP: begin
                    state_nxt = IDLE;
                    if (dat_s2 && ((^shift_q) ^ par_q)) frame_ok  = 1'b1;
                    else                                frame_err = 1'b1;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            clk_s1  <= 1'b1;
            clk_s2  <= 1'b1;
            clk_s3  <= 1'b1;
            dat_s1  <= 1'b1;
            dat_s2  <= 1'b1;
            shift_q <= 8'h00;
            bitcnt  <= 3'd0;
            par_q   <= 1'b0;
            tmr     <= '0;
        end else begin
            clk_s1 <= PS2_CLK;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= PS2_DAT;
            dat_s2 <= dat_s1;
            if (state == IDLE || fall) tmr <= '0;
            else                       tmr <= tmr + 1'b1;
            if (fall) begin
                case (state)
                    IDLE:    bitcnt <= 3'd0;
                    DATA: begin
                        shift_q <= {dat_s2, shift_q[7:1]};
                        bitcnt  <= bitcnt + 3'd1;
                    end
                    PARITY:  par_q <= dat_s2;
                    default: ;
                endcase
            end
        end
    end

    // a push into a full FIFO still lands when a pop frees the head slot that cycle
    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign data_rd = I_RD && !I_ADDR;
    assign stat_rd = I_RD && I_ADDR;
    assign pop     = data_rd && !empty;
    assign push    = frame_ok && (!full || pop);
    assign drop    = frame_ok && full && !pop;

    always_comb begin
        count_nxt = count;
        if (push && !pop)      count_nxt = count + 1'b1;
        else if (pop && !push) count_nxt = count - 1'b1;
    end

    assign irq_tgl   = (push && empty) || (pop && (count_nxt != '0));
    assign stat_byte = {4'(count), ferr, ovf, full, !empty};

    always_ff @(posedge CLOCK) begin
        if (push) mem[wr_ptr] <= shift_q;
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            ferr     <= 1'b0;
            ovf      <= 1'b0;
            O_DATA   <= 8'h00;
            IRQ_KEYB <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            ferr  <= frame_err | (ferr & ~stat_rd);
            ovf   <= drop | (ovf & ~stat_rd);
            if (data_rd)      O_DATA <= pop ? mem[rd_ptr] : 8'h00;
            else if (stat_rd) O_DATA <= stat_byte;
            if (irq_tgl) IRQ_KEYB <= ~IRQ_KEYB;
        end
    end
endmodule
